// File: rtl/io_pkg.sv
// Shared constants and helpers for the CPU-bus I/O responder: register
// addresses, display idle patterns and the seven-segment hex font.
package io_pkg;

  localparam logic [31:0] ADDR_DIG  = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TCNT = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_TDIV = 32'hFFFF_F024;
  localparam logic [31:0] ADDR_LED  = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW   = 32'hFFFF_F070;

  // All segments dark / all digits disabled (both are active-low).
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] EN_OFF  = 8'hFF;

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment scan engine. Each digit is lit for
// SCAN_DIV cycles; enables and segments are registered so the pins are glitch-free.
module seg_scan
  import io_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 20000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] dig,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] scnt;
  logic [2:0]       idx;
  logic [3:0]       nibble;

  assign nibble = dig[{idx, 2'b00} +: 4];

  // Dwell counter and digit index; idx advances once per SCAN_DIV cycles.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      scnt <= '0;
      idx  <= 3'd0;
    end else if (scnt == SCNT_LAST) begin
      scnt <= '0;
      idx  <= idx + 3'd1;
    end else begin
      scnt <= scnt + 1'b1;
    end
  end

  // Output stage: register enable and decoded segments of the current digit.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      dig_en  <= EN_OFF;
      dig_seg <= SEG_OFF;
    end else begin
      dig_en  <= ~(8'b1 << idx);
      dig_seg <= {1'b1, hex7(nibble)};
    end
  end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O responder on the core's data bus: display, LEDs,
// synchronized switches and a prescaled timer. Reads are combinational so a
// single-cycle MEM stage gets load data in the same cycle.
module io_responder
  import io_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 20000,
  parameter logic [31:0] TIMER_DIV_RST = 32'd0
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] Bus_addr,
  input  logic        Bus_wen,
  input  logic [31:0] Bus_wdata,
  output logic [31:0] Bus_rdata,
  input  logic [23:0] sw,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  logic [31:0] dig_reg;
  logic [31:0] tcnt;
  logic [31:0] tdiv;
  logic [31:0] pcnt;
  logic [23:0] sw_meta_p0;
  logic [23:0] sw_sync_p1;
  logic        sel_dig, sel_tcnt, sel_tdiv, sel_led, sel_sw;
  logic        we_dig, we_tcnt, we_tdiv, we_led;
  logic        tick;

  // Full 32-bit compares so nothing aliases into the map.
  assign sel_dig  = (Bus_addr == ADDR_DIG);
  assign sel_tcnt = (Bus_addr == ADDR_TCNT);
  assign sel_tdiv = (Bus_addr == ADDR_TDIV);
  assign sel_led  = (Bus_addr == ADDR_LED);
  assign sel_sw   = (Bus_addr == ADDR_SW);

  assign we_dig  = Bus_wen & sel_dig;
  assign we_tcnt = Bus_wen & sel_tcnt;
  assign we_tdiv = Bus_wen & sel_tdiv;
  assign we_led  = Bus_wen & sel_led;

  assign tick = (pcnt == tdiv);

  // Plain data registers written from the bus.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      dig_reg <= 32'd0;
      led     <= 24'd0;
    end else begin
      if (we_dig) dig_reg <= Bus_wdata;
      if (we_led) led     <= Bus_wdata[23:0];
    end
  end

  // Timer: prescaler wraps at TDIV; a TCNT write beats a same-cycle increment,
  // while a TDIV write lets that increment through. Either write restarts pcnt.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      pcnt <= 32'd0;
      tcnt <= 32'd0;
      tdiv <= TIMER_DIV_RST;
    end else begin
      if (we_tdiv) tdiv <= Bus_wdata;

      if (we_tcnt || we_tdiv || tick) pcnt <= 32'd0;
      else                            pcnt <= pcnt + 32'd1;

      if (we_tcnt)   tcnt <= Bus_wdata;
      else if (tick) tcnt <= tcnt + 32'd1;
    end
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      sw_meta_p0 <= 24'd0;
      sw_sync_p1 <= 24'd0;
    end else begin
      sw_meta_p0 <= sw;
      sw_sync_p1 <= sw_meta_p0;
    end
  end

  // Combinational read mux; unmapped addresses read as zero.
  always_comb begin
    Bus_rdata = 32'd0;
    if (sel_dig)       Bus_rdata = dig_reg;
    else if (sel_tcnt) Bus_rdata = tcnt;
    else if (sel_tdiv) Bus_rdata = tdiv;
    else if (sel_led)  Bus_rdata = {8'h00, led};
    else if (sel_sw)   Bus_rdata = {8'h00, sw_sync_p1};
  end

  seg_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_seg_scan (
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .dig    (dig_reg),
    .dig_en (dig_en),
    .dig_seg(dig_seg)
  );

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: directed literal checks plus randomized bus traffic
// compared every cycle against a behavioural model of the register map.
module tb_io_responder;

  localparam int unsigned SCAN_DIV = 4;
  localparam logic [31:0] A_DIG  = 32'hFFFF_F000;
  localparam logic [31:0] A_TCNT = 32'hFFFF_F020;
  localparam logic [31:0] A_TDIV = 32'hFFFF_F024;
  localparam logic [31:0] A_LED  = 32'hFFFF_F060;
  localparam logic [31:0] A_SW   = 32'hFFFF_F070;
  localparam logic [31:0] A_UNM  = 32'hFFFF_F074;

  localparam logic [7:0] FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E };

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic [31:0] Bus_addr = 32'd0;
  logic        Bus_wen = 1'b0;
  logic [31:0] Bus_wdata = 32'd0;
  logic [31:0] Bus_rdata;
  logic [23:0] sw = 24'd0;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;

  int n_checks = 0;
  int n_fail   = 0;

  io_responder #(.SCAN_DIV(SCAN_DIV), .TIMER_DIV_RST(32'd0)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rst  (cpu_rst),
    .Bus_addr (Bus_addr),
    .Bus_wen  (Bus_wen),
    .Bus_wdata(Bus_wdata),
    .Bus_rdata(Bus_rdata),
    .sw       (sw),
    .led      (led),
    .dig_en   (dig_en),
    .dig_seg  (dig_seg)
  );

  always #5 cpu_clk = ~cpu_clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_dig, m_dig_shown;
  logic [23:0] m_led;
  logic [23:0] m_swq[$];
  longint unsigned m_tbase, m_telap, m_tdiv;
  int m_n;  // active edges since reset release

  function automatic logic [31:0] m_tcnt();
    return 32'(m_tbase + m_telap / (m_tdiv + 1));
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [23:0] s;
    s = (m_swq.size() == 2) ? m_swq[0] : 24'd0;
    case (a)
      A_DIG:   return m_dig;
      A_TCNT:  return m_tcnt();
      A_TDIV:  return 32'(m_tdiv);
      A_LED:   return {8'h00, m_led};
      A_SW:    return {8'h00, s};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_dig = 0; m_dig_shown = 0; m_led = 0; m_swq.delete();
    m_tbase = 0; m_telap = 0; m_tdiv = 0; m_n = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge cpu_clk);
      if (cpu_rst === 1'b1) begin
        m_n++;
        m_dig_shown = m_dig;
        m_swq.push_back(sw);
        if (m_swq.size() > 2) void'(m_swq.pop_front());
        if (Bus_wen && Bus_addr == A_TCNT) begin
          m_tbase = Bus_wdata; m_telap = 0;
        end else if (Bus_wen && Bus_addr == A_TDIV) begin
          m_tbase = 32'(m_tbase + (m_telap + 1) / (m_tdiv + 1));
          m_telap = 0; m_tdiv = Bus_wdata;
        end else begin
          m_telap++;
        end
        if (Bus_wen && Bus_addr == A_DIG) m_dig = Bus_wdata;
        if (Bus_wen && Bus_addr == A_LED) m_led = Bus_wdata[23:0];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    int idx;
    logic [7:0] e_en, e_seg;
    forever begin
      @(negedge cpu_clk);
      if (cpu_rst !== 1'b1 || m_n == 0) begin
        e_en = 8'hFF; e_seg = 8'hFF;
      end else begin
        idx = ((m_n - 1) / int'(SCAN_DIV)) % 8;
        e_en = ~(8'b1 << idx);
        e_seg = FONT[m_dig_shown[idx*4 +: 4]];
      end
      check("cyc_led", {8'h0, led}, {8'h0, m_led});
      check("cyc_dig_en", {24'h0, dig_en}, {24'h0, e_en});
      check("cyc_dig_seg", {24'h0, dig_seg}, {24'h0, e_seg});
      check("cyc_rdata", Bus_rdata, model_read(Bus_addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge cpu_clk); #1; end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    Bus_addr = a; Bus_wdata = d; Bus_wen = 1'b1;
    @(posedge cpu_clk); #1;
    Bus_wen = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    Bus_addr = a; #1;
    check(name, Bus_rdata, exp);
  endtask

  task automatic wait_en(input logic [7:0] v, output bit ok);
    int budget;
    budget = 100;
    while (dig_en !== v && budget > 0) begin @(negedge cpu_clk); budget--; end
    ok = (dig_en === v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int pick;
    logic [31:0] a, d;

    step(3);
    cpu_rst = 1'b1;
    read_check("rst_DIG",  A_DIG,  32'h0);
    read_check("rst_TCNT", A_TCNT, 32'h0);
    read_check("rst_TDIV", A_TDIV, 32'h0);
    read_check("rst_LED",  A_LED,  32'h0);
    read_check("rst_SW",   A_SW,   32'h0);
    step(1);
    check("first_led", {8'h0, led}, 32'h0);
    check("first_dig_en", {24'h0, dig_en}, 32'hFE);
    check("first_dig_seg", {24'h0, dig_seg}, 32'hC0);

    bus_write(A_LED, 32'hFFAB_CDEF);
    read_check("led_rb", A_LED, 32'h00AB_CDEF);
    check("led_pin", {8'h0, led}, 32'h00AB_CDEF);
    bus_write(A_UNM, 32'h1234);
    read_check("unm_rd", A_UNM, 32'h0);
    read_check("unm_led", A_LED, 32'h00AB_CDEF);
    read_check("unm_dig", A_DIG, 32'h0);

    sw = 24'h5A5A5A;
    read_check("sw_lat0", A_SW, 32'h0);
    step(1);
    read_check("sw_lat1", A_SW, 32'h0);
    step(1);
    read_check("sw_lat2", A_SW, 32'h005A_5A5A);

    bus_write(A_TDIV, 32'd3);
    bus_write(A_TCNT, 32'd0);
    step(16);
    read_check("tmr_16cyc", A_TCNT, 32'd4);
    bus_write(A_TCNT, 32'hFFFF_FFFF);
    step(3);
    read_check("tmr_prewrap", A_TCNT, 32'hFFFF_FFFF);
    step(1);
    read_check("tmr_wrap", A_TCNT, 32'h0);
    step(3);
    bus_write(A_TCNT, 32'h55);
    read_check("tmr_wr_wins", A_TCNT, 32'h55);

    bus_write(A_DIG, 32'h8765_4321);
    wait_en(8'h7F, ok);
    check("scan_seen_7F", {31'h0, ok}, 32'h1);
    wait_en(8'hFE, ok);
    check("scan_seen_FE", {31'h0, ok}, 32'h1);
    check("scan_d0_seg", {24'h0, dig_seg}, 32'hF9);
    repeat (SCAN_DIV - 1) @(negedge cpu_clk);
    check("scan_d0_dwell", {24'h0, dig_en}, 32'hFE);
    @(negedge cpu_clk);
    check("scan_d1_en", {24'h0, dig_en}, 32'hFD);
    check("scan_d1_seg", {24'h0, dig_seg}, 32'hA4);
    step(1);

    for (int i = 0; i < 1500; i++) begin
      pick = $urandom_range(0, 6);
      case (pick)
        0: a = A_DIG;  1: a = A_TCNT; 2: a = A_TDIV; 3: a = A_LED;
        4: a = A_SW;   5: a = A_UNM;  default: a = $urandom;
      endcase
      d = (a == A_TDIV) ? 32'($urandom_range(0, 5)) : $urandom;
      Bus_addr = a; Bus_wdata = d; Bus_wen = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) sw = 24'($urandom);
      if (i == 700) begin
        // asynchronous reset mid-operation, with an LED write held across an edge
        @(posedge cpu_clk); #2;
        Bus_addr = A_LED; Bus_wdata = 32'h00FF_FFFF; Bus_wen = 1'b1;
        cpu_rst = 1'b0;
        model_reset();
        #1;
        check("arst_led", {8'h0, led}, 32'h0);
        check("arst_dig_en", {24'h0, dig_en}, 32'hFF);
        check("arst_dig_seg", {24'h0, dig_seg}, 32'hFF);
        check("arst_rd_led", Bus_rdata, 32'h0);
        Bus_addr = A_TCNT; #1;
        check("arst_rd_tcnt", Bus_rdata, 32'h0);
        Bus_addr = A_LED;
        @(posedge cpu_clk); #1;
        Bus_wen = 1'b0;
        cpu_rst = 1'b1;
        read_check("arst_wr_lost", A_LED, 32'h0);
      end
      step(1);
    end

    Bus_wen = 1'b0;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
